// File: rtl/intersection_pkg.sv
// Shared encodings for the intersection scheduler, light_controller and their benches.
package intersection_pkg;

    typedef enum logic [2:0] {
        S_NS_GRN   = 3'd0,
        S_NS_YEL   = 3'd1,
        S_AR_TO_EW = 3'd2,
        S_EW_GRN   = 3'd3,
        S_EW_YEL   = 3'd4,
        S_AR_TO_NS = 3'd5
    } state_e;

    localparam logic [1:0] LT_RED = 2'd0;
    localparam logic [1:0] LT_YEL = 2'd1;
    localparam logic [1:0] LT_GRN = 2'd3;

    // Colour shown by one approach, given its own green and yellow states.
    function automatic logic [1:0] light_of(input state_e s, input state_e grn, input state_e yel);
        if (s == grn) return LT_GRN;
        if (s == yel) return LT_YEL;
        return LT_RED;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating cycle counter for the time spent in the current scheduler phase.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (count_q != '1) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach signal sequencer: demand latches, min/max green, yellow and all-red clearance.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MIN_GREEN  = 10,
    parameter int unsigned MAX_GREEN  = 40,
    parameter int unsigned YELLOW_CYC = 4,
    parameter int unsigned ALLRED_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_car_i,
    input  logic       ew_car_i,
    output logic [1:0] ns_light_o,
    output logic [1:0] ew_light_o,
    output logic       ns_allow_o,
    output logic       ew_allow_o,
    output logic [2:0] phase_o
);

    localparam logic [CNT_W-1:0] MinLast    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MaxLast    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YelLast    = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALLRED_CYC - 1);

    state_e           state_q, state_d;
    logic             ns_req_q, ns_req_d;
    logic             ew_req_q, ew_req_d;
    logic             changing;
    logic [CNT_W-1:0] timer;

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_phase_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(changing),
        .count_o(timer)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_AR_TO_NS: if (timer == AllRedLast) state_d = S_NS_GRN;
            S_NS_GRN:   if (ew_req_q && timer >= MinLast) state_d = S_NS_YEL;
            S_NS_YEL:   if (timer == YelLast) state_d = S_AR_TO_EW;
            S_AR_TO_EW: if (timer == AllRedLast) state_d = S_EW_GRN;
            // Gap-out on a clear EW approach, or max-out when NS has been waiting.
            S_EW_GRN: begin
                if (timer >= MinLast && (!ew_car_i || (ns_req_q && timer >= MaxLast))) begin
                    state_d = S_EW_YEL;
                end
            end
            S_EW_YEL:   if (timer == YelLast) state_d = S_AR_TO_NS;
            default:    state_d = S_AR_TO_NS;
        endcase
        changing = (state_d != state_q);

        // Entry to an approach's green clears its demand, even against a same-cycle arrival.
        ns_req_d = ns_req_q;
        if (ns_car_i && state_q != S_NS_GRN) ns_req_d = 1'b1;
        if (changing && state_d == S_NS_GRN) ns_req_d = 1'b0;
        ew_req_d = ew_req_q;
        if (ew_car_i && state_q != S_EW_GRN) ew_req_d = 1'b1;
        if (changing && state_d == S_EW_GRN) ew_req_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_AR_TO_NS;
            ns_req_q   <= 1'b0;
            ew_req_q   <= 1'b0;
            ns_light_o <= LT_RED;
            ew_light_o <= LT_RED;
            ns_allow_o <= 1'b0;
            ew_allow_o <= 1'b0;
            phase_o    <= S_AR_TO_NS;
        end else begin
            state_q    <= state_d;
            ns_req_q   <= ns_req_d;
            ew_req_q   <= ew_req_d;
            ns_light_o <= light_of(state_d, S_NS_GRN, S_NS_YEL);
            ew_light_o <= light_of(state_d, S_EW_GRN, S_EW_YEL);
            ns_allow_o <= (state_d == S_NS_GRN);
            ew_allow_o <= (state_d == S_EW_GRN);
            phase_o    <= state_d;
        end
    end

    a_one_non_red: assert property (@(posedge clk) disable iff (!rst_n)
        !(ns_light_o != LT_RED && ew_light_o != LT_RED));
    a_ns_allow_own: assert property (@(posedge clk) disable iff (!rst_n)
        ns_allow_o |-> (state_q == S_NS_GRN));
    a_ew_allow_own: assert property (@(posedge clk) disable iff (!rst_n)
        ew_allow_o |-> (state_q == S_EW_GRN));
    a_allred_before_green: assert property (@(posedge clk) disable iff (!rst_n)
        (changing && (state_d == S_NS_GRN || state_d == S_EW_GRN)) |->
        ((state_q == S_AR_TO_NS || state_q == S_AR_TO_EW) && timer == AllRedLast));

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench: a phase-index reference model predicts every cycle, a monitor compares.
module tb_intersection_scheduler;
    import intersection_pkg::*;

    localparam int MIN_G = 10;
    localparam int MAX_G = 40;
    localparam int YEL_C = 4;
    localparam int AR_C  = 2;

    // Model phases in service order; leaving a phase always moves to the next one.
    localparam int P_NS_GRN = 0;
    localparam int P_NS_YEL = 1;
    localparam int P_AR_EW  = 2;
    localparam int P_EW_GRN = 3;
    localparam int P_EW_YEL = 4;
    localparam int P_AR_NS  = 5;

    typedef struct packed {
        logic [1:0] ns;
        logic [1:0] ew;
        logic       na;
        logic       ea;
        logic [2:0] ph;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ns_car, ew_car;
    logic [1:0] ns_light, ew_light;
    logic       ns_allow, ew_allow;
    logic [2:0] phase;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t e_mon, g_mon;

    int m_ph, m_t, nxt;
    bit m_nsr, m_ewr, m_in_reset, leave;

    intersection_scheduler #(
        .CNT_W     (8),
        .MIN_GREEN (MIN_G),
        .MAX_GREEN (MAX_G),
        .YELLOW_CYC(YEL_C),
        .ALLRED_CYC(AR_C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ns_car_i  (ns_car),
        .ew_car_i  (ew_car),
        .ns_light_o(ns_light),
        .ew_light_o(ew_light),
        .ns_allow_o(ns_allow),
        .ew_allow_o(ew_allow),
        .phase_o   (phase)
    );

    always #5 clk = ~clk;

    function automatic exp_t expect_of(input int ph);
        exp_t e;
        logic [2:0] code [6];
        code = '{S_NS_GRN, S_NS_YEL, S_AR_TO_EW, S_EW_GRN, S_EW_YEL, S_AR_TO_NS};
        e.ns = (ph == P_NS_GRN) ? 2'd3 : (ph == P_NS_YEL) ? 2'd1 : 2'd0;
        e.ew = (ph == P_EW_GRN) ? 2'd3 : (ph == P_EW_YEL) ? 2'd1 : 2'd0;
        e.na = (ph == P_NS_GRN);
        e.ea = (ph == P_EW_GRN);
        e.ph = code[ph];
        return e;
    endfunction

    // Reference model: one step per clock edge, reset replaces the pending prediction.
    initial begin
        m_in_reset = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = P_AR_NS; m_t = 0; m_nsr = 1'b0; m_ewr = 1'b0;
                if (m_in_reset) exp_q.push_back(expect_of(m_ph));
                else if (exp_q.size() != 0) exp_q[exp_q.size()-1] = expect_of(m_ph);
                m_in_reset = 1'b1;
            end else begin
                m_in_reset = 1'b0;
                case (m_ph)
                    P_NS_GRN: leave = m_ewr && (m_t + 1 >= MIN_G);
                    P_EW_GRN: leave = (m_t + 1 >= MIN_G) && (!ew_car || (m_nsr && m_t + 1 >= MAX_G));
                    P_NS_YEL, P_EW_YEL: leave = (m_t + 1 >= YEL_C);
                    default: leave = (m_t + 1 >= AR_C);
                endcase
                nxt = leave ? (m_ph + 1) % 6 : m_ph;
                if (ns_car && m_ph != P_NS_GRN) m_nsr = 1'b1;
                if (ew_car && m_ph != P_EW_GRN) m_ewr = 1'b1;
                if (nxt == P_NS_GRN && m_ph != P_NS_GRN) m_nsr = 1'b0;
                if (nxt == P_EW_GRN && m_ph != P_EW_GRN) m_ewr = 1'b0;
                m_t  = leave ? 0 : m_t + 1;
                m_ph = nxt;
                exp_q.push_back(expect_of(m_ph));
            end
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_mon = exp_q.pop_front();
            g_mon = '{ns: ns_light, ew: ew_light, na: ns_allow, ea: ew_allow, ph: phase};
            n_checks++;
            if (g_mon !== e_mon) begin
                n_errors++;
                $display("FAIL scoreboard t=%0t got ns=%0d ew=%0d na=%0b ea=%0b ph=%0d want ns=%0d ew=%0d na=%0b ea=%0b ph=%0d",
                         $time, g_mon.ns, g_mon.ew, g_mon.na, g_mon.ea, g_mon.ph,
                         e_mon.ns, e_mon.ew, e_mon.na, e_mon.ea, e_mon.ph);
            end
        end
        n_checks++;
        if ((ns_light != 2'd0 && ew_light != 2'd0) || (ns_allow && ns_light != 2'd3) ||
            (ew_allow && ew_light != 2'd3)) begin
            n_errors++;
            $display("FAIL safety t=%0t got ns=%0d ew=%0d na=%0b ea=%0b want one non-red, allow only on green",
                     $time, ns_light, ew_light, ns_allow, ew_allow);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s t=%0t got %0d want %0d", tag, $time, got, want);
        end
    endtask

    // Counts how long the current phase lasts; 'already' cycles of it have been seen.
    task automatic hold_len(input string tag, input int already, input int want);
        logic [2:0] p;
        int n;
        p = phase;
        n = already;
        tick();
        while (phase == p && n < 600) begin
            n++;
            tick();
        end
        check(tag, n, want);
    endtask

    task automatic wait_phase(input string tag, input logic [2:0] p);
        int k;
        k = 0;
        while (phase != p && k < 600) begin
            tick();
            k++;
        end
        check(tag, int'(phase), int'(p));
    endtask

    task automatic idle_ns(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ns_light != 2'd3 || ew_light != 2'd0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ew_hold, rst_hold;
        rst_n = 1'b0; ns_car = 1'b0; ew_car = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset release: two all-red cycles then NS green.
        check("t1_reset_ns", int'(ns_light), 0);
        hold_len("t1_allred", 1, AR_C);
        check("t1_ns_green", int'(ns_light), 3);
        check("t1_ns_allow", int'(ns_allow), 1);

        // EW pulse at NS timer 3: min green, yellow, all-red, EW green.
        repeat (3) tick();
        ew_car = 1'b1; tick(); ew_car = 1'b0;
        hold_len("t3_ns_green", 5, MIN_G);
        hold_len("t3_ns_yel", 1, YEL_C);
        ew_car = 1'b1;
        hold_len("t3_allred", 1, AR_C);
        check("t3_ew_green", int'(ew_light), 3);

        // Gap-out before min green still waits for min green.
        repeat (2) tick();
        ew_car = 1'b0;
        hold_len("t5_ew_min", 3, MIN_G);
        hold_len("t5_ew_yel", 1, YEL_C);
        hold_len("t5_allred_ns", 1, AR_C);

        // Gap-out after min green: yellow on the next cycle.
        ew_car = 1'b1; tick(); ew_car = 1'b0;
        hold_len("t5_ns_green", 2, MIN_G);
        ew_car = 1'b1;
        hold_len("t5_ns_yel", 1, YEL_C);
        hold_len("t5_allred_ew", 1, AR_C);
        repeat (15) tick();
        ew_car = 1'b0;
        hold_len("t5_ew_gap16", 16, 16);
        hold_len("t5_ew_yel2", 1, YEL_C);
        hold_len("t5_allred_ns2", 1, AR_C);

        // Max-out: EW held, NS demand arrives at EW timer 5.
        ew_car = 1'b1;
        hold_len("t4_ns_green", 1, MIN_G);
        hold_len("t4_ns_yel", 1, YEL_C);
        hold_len("t4_allred", 1, AR_C);
        repeat (5) tick();
        ns_car = 1'b1; tick(); ns_car = 1'b0;
        hold_len("t4_ew_max", 7, MAX_G);
        ew_car = 1'b0;
        hold_len("t4_ew_yel", 1, YEL_C);
        hold_len("t4_allred_ns", 1, AR_C);
        check("t4_ns_back", int'(ns_light), 3);

        // Rest on NS green with no demand.
        idle_ns("t2_rest_ns", 200);

        // Reset in EW yellow with EW demand pending.
        ew_car = 1'b1; tick(); ew_car = 1'b0;
        wait_phase("t6_reach_ew", S_EW_GRN);
        wait_phase("t6_reach_yel", S_EW_YEL);
        ew_car = 1'b1; tick(); ew_car = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_async_lights", int'({ns_light, ew_light}), 0);
        check("t6_async_allow", int'({ns_allow, ew_allow}), 0);
        check("t6_async_phase", int'(phase), int'(S_AR_TO_NS));
        repeat (2) tick();
        rst_n = 1'b1;
        hold_len("t6_allred", 1, AR_C);
        check("t6_ns_green", int'(ns_light), 3);
        idle_ns("t6_demand_gone", 50);

        // Randomized traffic with occasional resets.
        ew_hold = 0;
        for (int i = 0; i < 2500; i++) begin
            ns_car = ($urandom_range(0, 24) == 0);
            if (ew_hold > 0) begin
                ew_car = 1'b1;
                ew_hold--;
            end else begin
                ew_car = 1'b0;
                if ($urandom_range(0, 29) == 0) ew_hold = int'($urandom_range(1, 60));
            end
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                rst_hold = int'($urandom_range(1, 3));
                repeat (rst_hold) tick();
                rst_n = 1'b1;
            end
            tick();
        end
        ns_car = 1'b0; ew_car = 1'b0;
        repeat (2) tick();
        check("sb_backlog", exp_q.size() <= 1 ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
